sccb_reg_arbiter: RTL and testbench

Shares the single camera SCCB transaction engine (the i2c control FSM driving the OV7670 over the Wishbone I2C master) among several register-access requesters: the boot-time ROM init sequencer, runtime exposure/gain tuning and debug pokes. It grants one requester at a time using round-robin, and sequences the engine's store/send/ready handshake for each register write. It supervises each transaction with a timeout and returns a per-requester done or error pulse.

---
 rtl/sccb_reg_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_sccb_reg_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_reg_arbiter.sv
// sccb_reg_arbiter: round-robin arbiter that shares one SCCB/I2C control
// FSM among NUM_REQ register-access requesters and sequences its
// store/send/recv handshake with a per-wait-state timeout.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   req_i/we_i/addr_i/wdata_i per-requester request bundle (8-bit packed)
//   grant_o/done_o/err_o      per-requester owner, success, failure pulse
//   rdata_o                   read byte, valid with the done pulse
//   busy_o, err_sticky_o, timeout_o   status
//   fsm_store_o/send_o/recv_o, fsm_data_o   engine strobes and byte
//   fsm_rdy_i, fsm_err_i, fsm_rd_data_i     engine responses
//
// Optional feature: define SCCB_ARB_READ_EN to compile in the read path
// (RECV, WAIT_R, rdata capture). Without it reads fail immediately.
module sccb_reg_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   we_i,
    input  logic [8*NUM_REQ-1:0] addr_i,
    input  logic [8*NUM_REQ-1:0] wdata_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [NUM_REQ-1:0]   err_o,
    output logic [7:0]           rdata_o,
    output logic                 busy_o,
    output logic                 err_sticky_o,
    output logic                 timeout_o,
    output logic                 fsm_store_o,
    output logic                 fsm_send_o,
    output logic                 fsm_recv_o,
    output logic [7:0]           fsm_data_o,
    input  logic                 fsm_rdy_i,
    input  logic                 fsm_err_i,
    input  logic [7:0]           fsm_rd_data_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [3:0] {
        IDLE, ST_ADDR, ST_VAL, ST_END, KICK,
        KICK_CLR, WAIT_W, RECV, WAIT_R, RESP
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 fail_q, fail_d;
    logic [23:0]          cnt_q, cnt_d;
    logic                 err_sticky_q, err_sticky_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           rdata_q, rdata_d;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic [IW:0]          arb_sum;
    logic [7:0]           pick_addr;
    logic [7:0]           pick_wdata;
    logic                 pick_we;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 tmo_hit;
    logic                 fail_eng;
    logic                 fail_tmo;
    logic [23:0]          cnt_inc;

    // Wrap-around search starting just after the last-served index.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        arb_sum  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_sum = {1'b0, ptr_q} + (IW+1)'(i);
            if (arb_sum >= (IW+1)'(NUM_REQ)) begin
                arb_sum = arb_sum - (IW+1)'(NUM_REQ);
            end
            if (!pick_vld && req_i[arb_sum[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = arb_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_we    = 1'b0;
        pick_oh    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IW'(k)) begin
                pick_addr  = addr_i[8*k +: 8];
                pick_wdata = wdata_i[8*k +: 8];
                pick_we    = we_i[k];
                pick_oh[k] = 1'b1;
            end
        end
    end

    assign tmo_hit = (TIMEOUT_CYCLES != 24'd0) &&
                     (cnt_q == TIMEOUT_CYCLES - 24'd1);
    assign cnt_inc = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fail_d       = fail_q;
        cnt_d        = cnt_q;
        err_sticky_d = err_sticky_q;
        timeout_d    = timeout_q;
        rdata_d      = rdata_q;
        fail_eng     = 1'b0;
        fail_tmo     = 1'b0;
        fsm_store_o  = 1'b0;
        fsm_send_o   = 1'b0;
        fsm_recv_o   = 1'b0;
        fsm_data_o   = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ST_ADDR;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    we_d    = pick_we;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    fail_d  = 1'b0;
                end
            end
            ST_ADDR: begin
`ifdef SCCB_ARB_READ_EN
                fsm_store_o = 1'b1;
                fsm_data_o  = addr_q;
                state_d     = we_q ? ST_VAL : ST_END;
`else
                // Reads are not supported: fail without touching the engine.
                if (we_q) begin
                    fsm_store_o = 1'b1;
                    fsm_data_o  = addr_q;
                    state_d     = ST_VAL;
                end else begin
                    fail_d  = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            ST_VAL: begin
                fsm_store_o = 1'b1;
                fsm_data_o  = wdata_q;
                state_d     = ST_END;
            end
            ST_END: begin
                state_d = KICK;
            end
            KICK: begin
                fsm_send_o = 1'b1;
                cnt_d      = '0;
                state_d    = KICK_CLR;
            end
            // KICK_CLR is also the guard cycle of the write wait:
            // rdy is ignored, errors and timeout still count.
            KICK_CLR: begin
                if (fsm_err_i) begin
                    fail_eng = 1'b1;
                end else if (tmo_hit) begin
                    fail_tmo = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    state_d = WAIT_W;
                end
            end
            WAIT_W: begin
                if (fsm_err_i) begin
                    fail_eng = 1'b1;
                end else if (fsm_rdy_i) begin
`ifdef SCCB_ARB_READ_EN
                    state_d = we_q ? RESP : RECV;
`else
                    state_d = RESP;
`endif
                end else if (tmo_hit) begin
                    fail_tmo = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`ifdef SCCB_ARB_READ_EN
            RECV: begin
                fsm_recv_o = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_R;
            end
            // cnt_q == 0 marks the guard cycle (counter saturates).
            WAIT_R: begin
                if (fsm_err_i) begin
                    fail_eng = 1'b1;
                end else if ((cnt_q != 24'd0) && fsm_rdy_i) begin
                    rdata_d = fsm_rd_data_i;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    fail_tmo = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            RESP: begin
                grant_d = '0;
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (fail_eng || fail_tmo) begin
            state_d      = RESP;
            fail_d       = 1'b1;
            err_sticky_d = 1'b1;
            if (fail_tmo) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            ptr_q        <= IW'(NUM_REQ - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fail_q       <= 1'b0;
            cnt_q        <= '0;
            err_sticky_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            fail_q       <= fail_d;
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef SCCB_ARB_READ_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end
    assign rdata_o = rdata_q;
`else
    logic unused_rd;
    assign rdata_q   = '0;
    assign rdata_o   = '0;
    assign unused_rd = ^{fsm_rd_data_i, rdata_d};
`endif

    always_comb begin
        done_o = '0;
        err_o  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((state_q == RESP) && (owner_q == IW'(k))) begin
                done_o[k] = !fail_q;
                err_o[k]  = fail_q;
            end
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = (state_q != IDLE);
    assign err_sticky_o = err_sticky_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_sccb_reg_arbiter.sv
// tb_sccb_reg_arbiter: directed stimulus for sccb_reg_arbiter with a
// queue scoreboard checked by a monitor on every done/err pulse.
module tb_sccb_reg_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  req_i, we_i;
    logic [15:0] addr_i, wdata_i;
    logic [1:0]  grant_o, done_o, err_o;
    logic [7:0]  rdata_o;
    logic        busy_o, err_sticky_o, timeout_o;
    logic        fsm_store_o, fsm_send_o, fsm_recv_o;
    logic [7:0]  fsm_data_o;
    logic        fsm_rdy_i, fsm_err_i;
    logic [7:0]  fsm_rd_data_i;

    sccb_reg_arbiter #(
        .NUM_REQ(2),
        .TIMEOUT_CYCLES(24'd50)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .req_i(req_i),
        .we_i(we_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .grant_o(grant_o),
        .done_o(done_o),
        .err_o(err_o),
        .rdata_o(rdata_o),
        .busy_o(busy_o),
        .err_sticky_o(err_sticky_o),
        .timeout_o(timeout_o),
        .fsm_store_o(fsm_store_o),
        .fsm_send_o(fsm_send_o),
        .fsm_recv_o(fsm_recv_o),
        .fsm_data_o(fsm_data_o),
        .fsm_rdy_i(fsm_rdy_i),
        .fsm_err_i(fsm_err_i),
        .fsm_rd_data_i(fsm_rd_data_i)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         idx;
        bit         is_err;
        bit         chk_rd;
        logic [7:0] rd;
    } resp_t;

    resp_t sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    resp_cnt = 0;
    int    g_rise   = 0;
    logic [1:0] grant_prev = 2'b00;

    // engine model: 0 = rdy after delay, 1 = err pulse after delay, 2 = hang
    int eng_mode  = 0;
    int eng_delay = 10;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input bit e, input bit c,
                            input logic [7:0] rd);
        resp_t r;
        r.idx = idx; r.is_err = e; r.chk_rd = c; r.rd = rd;
        sb.push_back(r);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_resp(input int budget);
        int start;
        bit got;
        start = resp_cnt;
        got   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (resp_cnt != start) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL wait_resp: no response within %0d cycles", budget);
        end
    endtask

    initial begin
        fsm_rdy_i = 1'b0;
        fsm_err_i = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && (fsm_send_o || fsm_recv_o)) begin
                fsm_rdy_i = 1'b0;
                if (eng_mode == 0) begin
                    repeat (eng_delay) @(posedge sys_clk);
                    #1 fsm_rdy_i = 1'b1;
                end else if (eng_mode == 1) begin
                    repeat (eng_delay) @(posedge sys_clk);
                    #1 fsm_err_i = 1'b1;
                    @(posedge sys_clk);
                    #1 fsm_err_i = 1'b0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        resp_t e;
        logic [1:0] oh;
        if (!sys_rst_n) begin
            g_rise = resp_cnt;
        end else begin
            if (grant_o != 2'b00 && grant_prev == 2'b00) begin
                chk("grant_after_done", g_rise, resp_cnt);
                g_rise++;
            end
            if (fsm_store_o || fsm_send_o || fsm_recv_o) begin
                chk("strobe_onehot",
                    32'(fsm_store_o) + 32'(fsm_send_o) + 32'(fsm_recv_o), 1);
            end
            if ((done_o | err_o) != 2'b00) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: done=%b err=%b",
                             done_o, err_o);
                end else begin
                    e  = sb.pop_front();
                    oh = 2'b01 << e.idx;
                    chk("resp_kind", {done_o, err_o},
                        e.is_err ? {2'b00, oh} : {oh, 2'b00});
                    chk("resp_grant", grant_o, oh);
                    if (e.chk_rd) chk("resp_rdata", rdata_o, e.rd);
                end
            end
        end
        grant_prev = grant_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        sys_rst_n     = 1'b0;
        req_i         = '0;
        we_i          = '0;
        addr_i        = '0;
        wdata_i       = '0;
        fsm_rd_data_i = 8'h76;
        #12;
        chk("reset_outs", {grant_o, done_o, err_o, rdata_o, busy_o,
            err_sticky_o, timeout_o, fsm_store_o, fsm_send_o, fsm_recv_o,
            fsm_data_o}, 0);
        #10 sys_rst_n = 1'b1;
        tick();
        tick();

        // single write: req0 addr 0x12 data 0x80, rdy 10 cycles after send
        eng_mode = 0; eng_delay = 10;
        base = resp_cnt;
        push_exp(0, 1'b0, 1'b0, 8'h00);
        addr_i[7:0] = 8'h12; wdata_i[7:0] = 8'h80; we_i[0] = 1'b1;
        req_i[0] = 1'b1;
        tick();
        chk("w_grant_t1", grant_o, 2'b01);
        chk("w_busy_t1", busy_o, 1);
        chk("w_store_t1", {fsm_store_o, fsm_data_o}, {1'b1, 8'h12});
        req_i[0] = 1'b0; addr_i[7:0] = 8'hFF; wdata_i[7:0] = 8'hEE;
        tick();
        chk("w_store_t2", {fsm_store_o, fsm_data_o}, {1'b1, 8'h80});
        tick();
        chk("w_idle_t3", {fsm_store_o, fsm_send_o}, 0);
        tick();
        chk("w_send_t4", {fsm_store_o, fsm_send_o}, 2'b01);
        repeat (10) tick();
        chk("w_nodone_t14", done_o, 2'b00);
        tick();
        chk("w_done_t15", done_o, 2'b01);
        tick();
        chk("w_release_t16", {grant_o, busy_o}, 0);
        repeat (5) tick();
        chk("w_done_once", resp_cnt - base, 1);

        // rdy already high in the guard cycle must be ignored
        eng_mode = 0; eng_delay = 1;
        push_exp(1, 1'b0, 1'b0, 8'h00);
        addr_i[15:8] = 8'h34; wdata_i[15:8] = 8'h56; we_i[1] = 1'b1;
        req_i[1] = 1'b1;
        tick();
        chk("g_grant_t1", {grant_o, fsm_data_o}, {2'b10, 8'h34});
        req_i[1] = 1'b0;
        tick();
        chk("g_data_t2", fsm_data_o, 8'h56);
        repeat (4) tick();
        chk("g_nodone_t6", done_o, 2'b00);
        tick();
        chk("g_done_t7", done_o, 2'b10);
        repeat (3) tick();

        // contention: both requesting, expect 0,1,0,1
        eng_mode = 0; eng_delay = 3;
        push_exp(0, 1'b0, 1'b0, 8'h00);
        push_exp(1, 1'b0, 1'b0, 8'h00);
        push_exp(0, 1'b0, 1'b0, 8'h00);
        push_exp(1, 1'b0, 1'b0, 8'h00);
        addr_i = 16'h2120; wdata_i = 16'hB1A0; we_i = 2'b11;
        req_i = 2'b11;
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            tick();
            if ((done_o | err_o) != 2'b00) n++;
        end
        req_i = 2'b00;
        chk("c_four_done", n, 4);
        repeat (3) tick();

        // read request on requester 0
        addr_i[7:0] = 8'h0A; we_i[0] = 1'b0;
`ifdef SCCB_ARB_READ_EN
        eng_mode = 0; eng_delay = 3;
        push_exp(0, 1'b0, 1'b1, 8'h76);
        req_i[0] = 1'b1;
        tick();
        chk("r_store_t1", {fsm_store_o, fsm_data_o}, {1'b1, 8'h0A});
        req_i[0] = 1'b0;
        tick();
        chk("r_skip_val_t2", {fsm_store_o, fsm_send_o}, 0);
        wait_resp(60);
`else
        push_exp(0, 1'b1, 1'b0, 8'h00);
        req_i[0] = 1'b1;
        tick();
        chk("r_nostrobe_t1", {grant_o, fsm_store_o, fsm_send_o,
            fsm_recv_o, err_o}, {2'b01, 5'b0});
        req_i[0] = 1'b0;
        tick();
        chk("r_err_t2", {err_o, fsm_store_o, fsm_send_o}, {2'b01, 2'b00});
        tick();
        chk("r_nosticky", {busy_o, err_sticky_o}, 0);
`endif
        we_i[0] = 1'b1;
        repeat (3) tick();

        // engine error two cycles after send on requester 1
        eng_mode = 1; eng_delay = 2;
        push_exp(1, 1'b1, 1'b0, 8'h00);
        req_i[1] = 1'b1;
        tick();
        req_i[1] = 1'b0;
        wait_resp(40);
        tick();
        chk("e_status", {busy_o, err_sticky_o, timeout_o}, 3'b010);

        // timeout: engine never answers, 50 cycles from the guard at T+5
        eng_mode = 2;
        push_exp(0, 1'b1, 1'b0, 8'h00);
        req_i[0] = 1'b1;
        tick();
        req_i[0] = 1'b0;
        repeat (53) tick();
        chk("t_noerr_t54", {err_o, timeout_o}, 0);
        tick();
        chk("t_err_t55", {err_o, timeout_o}, 3'b011);
        repeat (3) tick();

        // reset during WAIT_W, then req0 must win a tie
        eng_mode = 2;
        req_i[1] = 1'b1;
        tick();
        req_i[1] = 1'b0;
        repeat (6) tick();
        chk("x_busy_before", {busy_o, grant_o}, 3'b110);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("x_async_clear", {grant_o, done_o, err_o, rdata_o, busy_o,
            err_sticky_o, timeout_o, fsm_store_o, fsm_send_o, fsm_recv_o,
            fsm_data_o}, 0);
        #10 sys_rst_n = 1'b1;
        tick();
        eng_mode = 0; eng_delay = 2;
        push_exp(0, 1'b0, 1'b0, 8'h00);
        addr_i = 16'h4544; we_i = 2'b11;
        req_i = 2'b11;
        tick();
        chk("x_first_grant", grant_o, 2'b01);
        req_i = 2'b00;
        wait_resp(40);
        repeat (3) tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
